hidden_layer: RTL and testbench
===============================

HIDDEN_LAYER -- requirements
Module: hidden_layer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: weight width in bits, signed two's complement.
REQ-002 SHALL have parameter HEIGHT, default 7: number of hidden neurons, which is the width of the spike vector fed downstream.
REQ-003 SHALL have parameter NUM_INPUTS, default 4: input spike lines per frame.
REQ-004 SHALL have parameter THRESHOLD, default 128: signed firing threshold.
REQ-005 SHALL have parameter LEAK_SHIFT, default 2: leak is membrane arithmetic-right-shifted by this amount.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: an input spike frame is offered.
REQ-009 SHALL have port in_spikes, input, NUM_INPUTS bits: input spike frame.
REQ-010 SHALL have port in_ready, output, 1 bit: high when a frame can be accepted.
REQ-011 SHALL have port w_we, input, 1 bit: weight write enable.
REQ-012 SHALL have port w_addr, input, $clog2(HEIGHT*NUM_INPUTS) bits: weight index, h*NUM_INPUTS+i.
REQ-013 SHALL have port w_data, input, WIDTH bits: signed weight value.
REQ-014 SHALL have port spikes, output, HEIGHT bits: registered spike vector, held stable between updates.
REQ-015 SHALL have port spikes_valid, output, 1 bit: one-cycle pulse when spikes has just been updated.

Function
REQ-016 SHALL implement states IDLE, ACCUM, FIRE and DONE; in_ready SHALL equal (state==IDLE).
REQ-017 SHALL, in IDLE with in_valid=1 at an edge (the acceptance edge, cycle 0), latch in_spikes, set h=0 and i=0, and enter ACCUM.
REQ-018 SHALL, in ACCUM, add weight[h][i] to mem[h] if latched bit i is 1, then increment i; on i==NUM_INPUTS-1 it SHALL enter FIRE.
REQ-019 SHALL, in FIRE, treat mem[h]>=THRESHOLD as a fire: set a pending bit h and clear mem[h] to 0.
REQ-020 SHALL, in FIRE when mem[h]<THRESHOLD, clear pending bit h and set mem[h] = mem[h] - (mem[h]>>>LEAK_SHIFT).
REQ-021 SHALL, on leaving FIRE, set i=0 and h=h+1 and return to ACCUM, except when h==HEIGHT-1, in which case it SHALL enter DONE.
REQ-022 SHALL, in DONE, copy pending into spikes, pulse spikes_valid for exactly one cycle, and return to IDLE.
REQ-023 SHALL have a fixed latency: spikes and spikes_valid change at edge HEIGHT*(NUM_INPUTS+1)+1 after acceptance (36 with defaults); the next frame is acceptable one cycle later.
REQ-024 SHALL hold each mem[h] as signed WIDTH+2 bits and saturate every addition to [-2^(WIDTH+1), 2^(WIDTH+1)-1], i.e. [-512, 511] with defaults, with no wrap-around.
REQ-025 SHALL ignore in_valid while not in IDLE; a frame offered while busy is dropped, not queued.
REQ-026 SHALL perform weight writes only in IDLE; w_we outside IDLE, or with w_addr >= HEIGHT*NUM_INPUTS, SHALL have no effect.
REQ-027 SHALL give priority to the frame when w_we and in_valid are both asserted in IDLE: both the write and the acceptance occur at that edge, and the frame uses the new weight.
REQ-028 SHALL change spikes only in DONE, so the downstream output stage may sample any bit at any time.

Reset
REQ-029 SHALL, on rst low and regardless of clk or state, go to IDLE; clear all mem, weights, pending and spikes to 0; set spikes_valid=0, h=0 and i=0; set in_ready=1 while rst is low.
REQ-030 SHALL discard a frame in progress when reset is asserted mid-operation; no spikes_valid is produced for it.
REQ-031 SHALL accept frames on the first rising edge after rst returns high.

Verification
REQ-032 SHALL cover power-up: rst=0 for 2 cycles -> spikes=0, spikes_valid=0, in_ready=1; a frame with all weights 0 gives spikes=0 at cycle 36.
REQ-033 SHALL cover a single fire: write w[0]=100 and w[1]=50, send in_spikes=4'b0011 -> spikes_valid at cycle 36 with spikes=7'b0000001; in_ready is low during cycles 1..36.
REQ-034 SHALL cover leak: write w[4]=64 (neuron 1, input 0), send 3 frames of 4'b0001 -> mem1 goes 48, then 84, then fires; spikes[1]=0, 0, 1 on the three pulses, with mem1=0 afterwards.
REQ-035 SHALL cover saturation: neuron 2 weights all -128, 2 frames of 4'b1111 -> no fire, and mem2 is -384 after each frame; then weights all 127 and 1 frame gives -384+508=124 -> spikes[2]=0.
REQ-036 SHALL cover busy handling: in_valid and w_we pulsed at cycle 10 -> no effect, exactly one spikes_valid is produced, and the weight value is unchanged.
REQ-037 SHALL cover reset mid-operation: rst low at cycle 20 -> no spikes_valid, spikes=0, weights read back as 0 (the next frame with 4'b1111 gives spikes=0).

Source files
------------

// File: rtl/hidden_layer.sv
// hidden_layer: one layer of leaky integrate-and-fire neurons.
//
// An accepted input spike frame is applied to each hidden neuron in turn.
// For neuron h, every set input bit i adds weight[h*NUM_INPUTS+i] to the
// membrane (saturating), and a FIRE step then either fires (membrane
// >= THRESHOLD, membrane cleared) or leaks (membrane -= membrane >>> LEAK_SHIFT).
// After the last neuron the pending fire bits are published on spikes with
// a one-cycle spikes_valid pulse. Latency is HEIGHT*(NUM_INPUTS+1)+1 edges.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     input frame offered (sampled only when idle)
//   in_spikes    input spike frame, NUM_INPUTS bits
//   in_ready     high while idle
//   w_we         weight write enable (idle only)
//   w_addr       weight index h*NUM_INPUTS+i
//   w_data       signed weight value
//   spikes       registered hidden spike vector, changes only when published
//   spikes_valid one-cycle pulse when spikes was just updated
module hidden_layer #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 7,
  parameter int NUM_INPUTS = 4,
  parameter int THRESHOLD  = 128,
  parameter int LEAK_SHIFT = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [NUM_INPUTS-1:0]                 in_spikes,
  output logic                                  in_ready,
  input  logic                                  w_we,
  input  logic [$clog2(HEIGHT*NUM_INPUTS)-1:0]  w_addr,
  input  logic [WIDTH-1:0]                      w_data,
  output logic [HEIGHT-1:0]                     spikes,
  output logic                                  spikes_valid
);

  localparam int NW = HEIGHT * NUM_INPUTS;
  localparam int AW = $clog2(NW);
  localparam int HW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int MW = WIDTH + 2;
  localparam int HL = HEIGHT - 1;
  localparam int IL = NUM_INPUTS - 1;

  localparam logic [AW:0]          NW_L    = NW[AW:0];
  localparam logic [AW-1:0]        NI_L    = NUM_INPUTS[AW-1:0];
  localparam logic [HW-1:0]        H_LAST  = HL[HW-1:0];
  localparam logic [IW-1:0]        I_LAST  = IL[IW-1:0];
  localparam logic signed [MW-1:0] THR     = THRESHOLD[MW-1:0];
  localparam logic [MW-1:0]        MEM_MAX = {1'b0, {(MW-1){1'b1}}};
  localparam logic [MW-1:0]        MEM_MIN = {1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [HW-1:0]           h_q, h_d;
  logic [IW-1:0]           i_q, i_d;
  logic [NUM_INPUTS-1:0]   frame_q, frame_d;
  logic signed [MW-1:0]    mem_q [HEIGHT];
  logic signed [MW-1:0]    mem_d [HEIGHT];
  logic [WIDTH-1:0]        w_q [NW];
  logic [WIDTH-1:0]        w_d [NW];
  logic [HEIGHT-1:0]       pend_q, pend_d;
  logic [HEIGHT-1:0]       spikes_q, spikes_d;
  logic                    valid_q, valid_d;

  logic [AW-1:0]           widx;
  logic [WIDTH-1:0]        wcur;
  logic [MW:0]             sum;

  assign in_ready     = (state_q == IDLE);
  assign spikes       = spikes_q;
  assign spikes_valid = valid_q;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    i_d      = i_q;
    frame_d  = frame_q;
    mem_d    = mem_q;
    w_d      = w_q;
    pend_d   = pend_q;
    spikes_d = spikes_q;
    valid_d  = 1'b0;
    widx     = AW'(h_q) * NI_L + AW'(i_q);
    wcur     = w_q[widx];
    // One guard bit above the membrane width: overflow shows as the top two
    // bits disagreeing, and the top bit then tells which rail to clamp to.
    sum      = {mem_q[h_q][MW-1], mem_q[h_q]} + {{3{wcur[WIDTH-1]}}, wcur};

    unique case (state_q)
      IDLE: begin
        // The write lands at the same edge as a frame acceptance, so the
        // frame's later accumulation already sees the new weight.
        if (w_we && ({1'b0, w_addr} < NW_L)) begin
          w_d[w_addr] = w_data;
        end
        if (in_valid) begin
          frame_d = in_spikes;
          h_d     = '0;
          i_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (frame_q[i_q]) begin
          if (sum[MW] != sum[MW-1]) begin
            mem_d[h_q] = sum[MW] ? MEM_MIN : MEM_MAX;
          end else begin
            mem_d[h_q] = sum[MW-1:0];
          end
        end
        i_d = i_q + 1'b1;
        if (i_q == I_LAST) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        if (mem_q[h_q] >= THR) begin
          pend_d[h_q] = 1'b1;
          mem_d[h_q]  = '0;
        end else begin
          pend_d[h_q] = 1'b0;
          mem_d[h_q]  = mem_q[h_q] - (mem_q[h_q] >>> LEAK_SHIFT);
        end
        i_d = '0;
        if (h_q == H_LAST) begin
          state_d = DONE;
        end else begin
          h_d     = h_q + 1'b1;
          state_d = ACCUM;
        end
      end
      DONE: begin
        spikes_d = pend_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      h_q      <= '0;
      i_q      <= '0;
      frame_q  <= '0;
      pend_q   <= '0;
      spikes_q <= '0;
      valid_q  <= 1'b0;
      for (int unsigned k = 0; k < HEIGHT; k++) mem_q[k] <= '0;
      for (int unsigned k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      i_q      <= i_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
      spikes_q <= spikes_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
      w_q      <= w_d;
    end
  end

endmodule

// File: tb/tb_hidden_layer.sv
// Directed bench for hidden_layer with an expected-spikes scoreboard.
module tb_hidden_layer;

  localparam int W   = 8;
  localparam int H   = 7;
  localparam int N   = 4;
  localparam int NW  = H * N;
  localparam int AW  = $clog2(NW);
  localparam int LAT = H * (N + 1) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_spikes = '0;
  logic          in_ready;
  logic          w_we = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [W-1:0]  w_data = '0;
  logic [H-1:0]  spikes;
  logic          spikes_valid;

  hidden_layer #(
    .WIDTH(W), .HEIGHT(H), .NUM_INPUTS(N), .THRESHOLD(128), .LEAK_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_spikes(in_spikes),
    .in_ready(in_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .spikes(spikes), .spikes_valid(spikes_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int npulse = 0;
  int npush = 0;

  typedef struct { logic [H-1:0] sp; int cyc; } exp_t;
  exp_t sb[$];

  // Reference model state
  int wm [NW];
  int mm [H];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [H-1:0] model(input logic [N-1:0] f);
    logic [H-1:0] r = '0;
    for (int h = 0; h < H; h++) begin
      for (int i = 0; i < N; i++) begin
        if (f[i]) begin
          mm[h] = mm[h] + wm[h*N+i];
          if (mm[h] > 511) mm[h] = 511;
          if (mm[h] < -512) mm[h] = -512;
        end
      end
      if (mm[h] >= 128) begin
        r[h] = 1'b1;
        mm[h] = 0;
      end else begin
        mm[h] = mm[h] - (mm[h] >>> 2);
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NW; k++) wm[k] = 0;
    for (int k = 0; k < H; k++) mm[k] = 0;
  endtask

  always @(negedge clk) begin
    if (rst && spikes_valid) begin
      npulse++;
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("spikes", spikes, e.sp);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic write_w(input int a, input int d);
    w_we = 1'b1;
    w_addr = a[AW-1:0];
    w_data = d[W-1:0];
    @(posedge clk);
    #1;
    w_we = 1'b0;
    if (a < NW) wm[a] = d;
  endtask

  task automatic offer(input logic [N-1:0] f);
    exp_t e;
    in_valid = 1'b1;
    in_spikes = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.cyc = cyc + LAT;
    e.sp = model(f);
    sb.push_back(e);
    npush++;
  endtask

  task automatic drain(input string tag);
    int busy_hi = 0;
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      if (!rst) break;
      if (in_ready) busy_hi++;
      @(negedge clk);
      #1;
    end
    check({tag, "_drain"}, sb.size(), 0);
    check({tag, "_busy_ready"}, busy_hi, 0);
  endtask

  initial begin
    model_reset();
    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_spikes", spikes, 0);
    check("rst_valid", spikes_valid, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    // All-zero weights, accepted on the first edge after release
    offer(4'b1111);
    drain("zero");

    // Single fire; out-of-range address write is ignored
    write_w(0, 100);
    write_w(1, 50);
    write_w(28, 127);
    offer(4'b0011);
    drain("single");
    check("single_mem0", dut.mem_q[0], 0);

    // Leak on neuron 1
    write_w(4, 64);
    offer(4'b0001); drain("leak1"); check("leak1_mem1", dut.mem_q[1], 48);
    offer(4'b0001); drain("leak2"); check("leak2_mem1", dut.mem_q[1], 84);
    offer(4'b0001); drain("leak3"); check("leak3_mem1", dut.mem_q[1], 0);

    // Saturation on neuron 2
    for (int k = 8; k < 12; k++) write_w(k, -128);
    offer(4'b1111); drain("sat1"); check("sat1_mem2", dut.mem_q[2], -384);
    offer(4'b1111); drain("sat2"); check("sat2_mem2", dut.mem_q[2], -384);
    for (int k = 8; k < 12; k++) write_w(k, 127);
    offer(4'b1111); drain("sat3"); check("sat3_mem2", dut.mem_q[2], 93);

    // Busy: frame and write offered mid-frame are dropped
    offer(4'b0011);
    repeat (9) @(posedge clk);
    #1;
    in_valid = 1'b1; w_we = 1'b1; w_addr = '0; w_data = 8'd55; in_spikes = 4'b1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0; w_we = 1'b0;
    drain("busy");
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("busy_pulses", npulse, npush);
    check("busy_weight", dut.w_q[0], wm[0]);

    // Reset mid-frame
    offer(4'b1111);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    npush--;
    model_reset();
    @(negedge clk);
    check("midrst_spikes", spikes, 0);
    check("midrst_valid", spikes_valid, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    offer(4'b1111);
    drain("postrst");
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("total_pulses", npulse, npush);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
